// File: rtl/risc_pkg.sv
// Shared definitions for the RISC control path: opcodes, phase indices,
// sequencer modes and the phase-to-{clk1,clk2,fch} encoding.
package risc_pkg;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam logic [2:0] P0 = 3'd0;
    localparam logic [2:0] P1 = 3'd1;
    localparam logic [2:0] P2 = 3'd2;
    localparam logic [2:0] P3 = 3'd3;
    localparam logic [2:0] P4 = 3'd4;
    localparam logic [2:0] P5 = 3'd5;
    localparam logic [2:0] P6 = 3'd6;
    localparam logic [2:0] P7 = 3'd7;

    typedef enum logic [1:0] {
        MODE_STOP = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_STEP = 2'd2,
        MODE_HALT = 2'd3
    } mode_t;

    // Returns {clk1, clk2, fch}; fch is high for the fetch half P0..P3.
    function automatic logic [2:0] phase_to_seq(input logic [2:0] ph);
        logic [2:0] seq;
        case (ph)
            P0:      seq = 3'b011;
            P1:      seq = 3'b111;
            P2:      seq = 3'b001;
            P3:      seq = 3'b101;
            P4:      seq = 3'b010;
            P5:      seq = 3'b110;
            P6:      seq = 3'b000;
            default: seq = 3'b100;
        endcase
        return seq;
    endfunction

endpackage

// File: rtl/phase_encode.sv
// Combinational phase decode: {clk1,clk2,fch} for a phase index, plus whether
// that phase touches memory for the given opcode.
module phase_encode
    import risc_pkg::*;
(
    input  logic [2:0] ph_i,
    input  logic [2:0] opcd_i,
    output logic [2:0] seq_o,
    output logic       mem_o
);

    logic op_uses_mem;

    assign seq_o = phase_to_seq(ph_i);

    // Only ADD/AND/XOR/LDA go to memory during the execute half.
    always_comb begin
        op_uses_mem = (opcd_i >= OP_ADD) && (opcd_i <= OP_LDA);
        mem_o       = ((ph_i >= P1) && (ph_i <= P3)) ||
                      ((ph_i >= P5) && op_uses_mem);
    end

endmodule

// File: rtl/risc_phase_sequencer.sv
// 8-phase instruction sequencer with STOP/RUN/STEP/HALT run control, memory
// stall and retired-instruction counter. Single-step mode needs PHSEQ_STEP_EN.
module risc_phase_sequencer
    import risc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic [2:0]       opcd,
    input  logic             mem_rdy,
    output logic             clk1,
    output logic             clk2,
    output logic             fch,
    output logic [2:0]       phase,
    output logic             halted,
    output logic             busy,
    output logic [CNT_W-1:0] instr_count
);

    mode_t            mode_q, mode_d;
    logic [2:0]       phase_q, phase_d;
    logic [2:0]       seq_q, seq_d;
    logic             halted_q, halted_d;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_phase;
    logic             stall;
    logic [2:0]       seq_cur_unused;
    logic             mem_nxt_unused;

`ifndef PHSEQ_STEP_EN
    logic step_unused;
    assign step_unused = step;
`endif

    phase_encode u_enc_cur (
        .ph_i   (phase_q),
        .opcd_i (opcd),
        .seq_o  (seq_cur_unused),
        .mem_o  (mem_phase)
    );

    // Encoding of the next phase is registered so the decoder sees clean edges.
    phase_encode u_enc_nxt (
        .ph_i   (phase_d),
        .opcd_i (opcd),
        .seq_o  (seq_d),
        .mem_o  (mem_nxt_unused)
    );

    assign stall = mem_phase && !mem_rdy;

    always_comb begin
        mode_d   = mode_q;
        phase_d  = phase_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        case (mode_q)
            MODE_STOP: begin
                phase_d = P0;
                if (run) begin
                    mode_d  = MODE_RUN;
                    phase_d = P1;
                end
`ifdef PHSEQ_STEP_EN
                else if (step) begin
                    mode_d  = MODE_STEP;
                    phase_d = P1;
                end
`endif
            end
`ifdef PHSEQ_STEP_EN
            MODE_RUN, MODE_STEP: begin
`else
            MODE_RUN: begin
`endif
                // A stalled cycle neither advances, counts nor honours a stop.
                if (!stall) begin
                    if ((phase_q == P4) && (opcd == OP_HLT)) begin
                        mode_d   = MODE_HALT;
                        phase_d  = P0;
                        halted_d = 1'b1;
                        cnt_d    = cnt_q + CNT_W'(1);
                    end else if (phase_q == P7) begin
                        phase_d = P0;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if ((mode_q == MODE_STEP) || !run)
                            mode_d = MODE_STOP;
                    end else begin
                        phase_d = phase_q + 3'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q   <= MODE_STOP;
            phase_q  <= P0;
            seq_q    <= phase_to_seq(P0);
            halted_q <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mode_q   <= mode_d;
            phase_q  <= phase_d;
            seq_q    <= seq_d;
            halted_q <= halted_d;
            busy_q   <= (mode_d == MODE_RUN) || (mode_d == MODE_STEP);
            cnt_q    <= cnt_d;
        end
    end

    assign {clk1, clk2, fch} = seq_q;
    assign phase             = phase_q;
    assign halted            = halted_q;
    assign busy              = busy_q;
    assign instr_count       = cnt_q;

endmodule

// File: tb/tb_risc_phase_sequencer.sv
// Self-checking bench for risc_phase_sequencer: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_risc_phase_sequencer;

    localparam int CNT_W   = 4;
    localparam int CNT_MOD = 1 << CNT_W;
    localparam int M_STOP  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STEP  = 2;
    localparam int M_HALT  = 3;
`ifdef PHSEQ_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             run = 1'b0;
    logic             step = 1'b0;
    logic [2:0]       opcd = 3'b010;
    logic             mem_rdy = 1'b1;
    logic             clk1, clk2, fch, halted, busy;
    logic [2:0]       phase;
    logic [CNT_W-1:0] instr_count;

    int total = 0;
    int bad   = 0;

    int m_mode   = M_STOP;
    int m_phase  = 0;
    int m_cnt    = 0;
    bit m_halted = 1'b0;
    bit step_en  = STEP_EN;

    risc_phase_sequencer #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .step        (step),
        .opcd        (opcd),
        .mem_rdy     (mem_rdy),
        .clk1        (clk1),
        .clk2        (clk2),
        .fch         (fch),
        .phase       (phase),
        .halted      (halted),
        .busy        (busy),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_seq(input int p);
        logic [2:0] t [8];
        t = '{3'b011, 3'b111, 3'b001, 3'b101, 3'b010, 3'b110, 3'b000, 3'b100};
        return t[p % 8];
    endfunction

    function automatic bit is_mem(input int p, input logic [2:0] op);
        return ((p >= 1) && (p <= 3)) || ((p >= 5) && (op >= 3'd2) && (op <= 3'd5));
    endfunction

    // Advance the model from the inputs as they stand, then clock the DUT.
    task automatic tick();
        if (!rst) begin
            m_mode = M_STOP; m_phase = 0; m_cnt = 0; m_halted = 1'b0;
        end else begin
            case (m_mode)
                M_STOP: begin
                    if (run) begin
                        m_mode = M_RUN; m_phase = 1;
                    end else if (step_en && step) begin
                        m_mode = M_STEP; m_phase = 1;
                    end
                end
                M_RUN, M_STEP: begin
                    if (!(is_mem(m_phase, opcd) && !mem_rdy)) begin
                        if (m_phase == 4 && opcd == 3'b000) begin
                            m_mode = M_HALT; m_phase = 0; m_halted = 1'b1;
                            m_cnt = (m_cnt + 1) % CNT_MOD;
                        end else begin
                            m_phase = (m_phase + 1) % 8;
                            if (m_phase == 0) begin
                                m_cnt = (m_cnt + 1) % CNT_MOD;
                                if (m_mode == M_STEP || !run) m_mode = M_STOP;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; run = 1'b0; step = 1'b0; mem_rdy = 1'b1;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; run = 1'b1; step = 1'b1;
        tick();
        total++;
        if ({clk1, clk2, fch} !== 3'b011 || phase !== 3'd0 || halted !== 1'b0 ||
            busy !== 1'b0 || instr_count !== 4'd0) begin
            bad++;
            $display("FAIL reset got seq=%b ph=%0d h=%b b=%b cnt=%0d exp seq=011 ph=0 h=0 b=0 cnt=0",
                     {clk1, clk2, fch}, phase, halted, busy, instr_count);
        end
        rst = 1'b1; run = 1'b0; step = 1'b0;
    endtask

    task automatic test_run_seq();
        do_reset();
        opcd = 3'b010; run = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            total++;
            if ({clk1, clk2, fch} !== exp_seq(k) || phase !== 3'(k % 8) || busy !== 1'b1) begin
                bad++;
                $display("FAIL run_seq k=%0d got seq=%b ph=%0d b=%b exp seq=%b ph=%0d b=1",
                         k, {clk1, clk2, fch}, phase, busy, exp_seq(k), k % 8);
            end
        end
        total++;
        if (instr_count !== 4'd2) begin
            bad++;
            $display("FAIL run_count got %0d exp 2", instr_count);
        end
    endtask

    task automatic test_stall();
        do_reset();
        opcd = 3'b010; run = 1'b1;
        tick(); tick();
        mem_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (phase !== 3'd2) begin
                bad++;
                $display("FAIL stall_hold k=%0d got ph=%0d exp 2", k, phase);
            end
        end
        mem_rdy = 1'b1;
        tick();
        total++;
        if (phase !== 3'd3 || {clk1, clk2, fch} !== 3'b101) begin
            bad++;
            $display("FAIL stall_resume got ph=%0d seq=%b exp ph=3 seq=101", phase, {clk1, clk2, fch});
        end
        repeat (4) tick();
        total++;
        if (phase !== 3'd7 || instr_count !== 4'd0) begin
            bad++;
            $display("FAIL stall_p7 got ph=%0d cnt=%0d exp ph=7 cnt=0", phase, instr_count);
        end
        tick();
        total++;
        if (phase !== 3'd0 || instr_count !== 4'd1) begin
            bad++;
            $display("FAIL stall_count got ph=%0d cnt=%0d exp ph=0 cnt=1", phase, instr_count);
        end
    endtask

    task automatic test_halt();
        do_reset();
        opcd = 3'b000; run = 1'b1;
        repeat (4) tick();
        total++;
        if (phase !== 3'd4 || busy !== 1'b1 || halted !== 1'b0) begin
            bad++;
            $display("FAIL halt_p4 got ph=%0d b=%b h=%b exp ph=4 b=1 h=0", phase, busy, halted);
        end
        tick();
        total++;
        if (phase !== 3'd0 || halted !== 1'b1 || busy !== 1'b0 || instr_count !== 4'd1 ||
            {clk1, clk2, fch} !== 3'b011) begin
            bad++;
            $display("FAIL halt_enter got ph=%0d h=%b b=%b cnt=%0d exp ph=0 h=1 b=0 cnt=1",
                     phase, halted, busy, instr_count);
        end
        for (int k = 0; k < 6; k++) begin
            run = 1'($urandom); step = 1'($urandom); opcd = 3'($urandom);
            tick();
            total++;
            if (phase !== 3'd0 || halted !== 1'b1 || busy !== 1'b0 || instr_count !== 4'd1) begin
                bad++;
                $display("FAIL halt_stay k=%0d got ph=%0d h=%b b=%b cnt=%0d exp ph=0 h=1 b=0 cnt=1",
                         k, phase, halted, busy, instr_count);
            end
        end
        run = 1'b0; step = 1'b0;
    endtask

    task automatic test_step();
        do_reset();
        opcd = 3'b010; run = 1'b0; step = 1'b1;
        tick();
        step = 1'b0;
`ifdef PHSEQ_STEP_EN
        total++;
        if (phase !== 3'd1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL step_start got ph=%0d b=%b exp ph=1 b=1", phase, busy);
        end
        for (int k = 2; k <= 8; k++) begin
            step = (k == 3);
            tick();
            total++;
            if (phase !== 3'(k % 8) || busy !== (k < 8)) begin
                bad++;
                $display("FAIL step_adv k=%0d got ph=%0d b=%b exp ph=%0d b=%0d",
                         k, phase, busy, k % 8, k < 8);
            end
        end
        step = 1'b0;
        repeat (2) tick();
        total++;
        if (phase !== 3'd0 || busy !== 1'b0 || instr_count !== 4'd1) begin
            bad++;
            $display("FAIL step_done got ph=%0d b=%b cnt=%0d exp ph=0 b=0 cnt=1", phase, busy, instr_count);
        end
`else
        total++;
        if (phase !== 3'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL step_ignored got ph=%0d b=%b exp ph=0 b=0", phase, busy);
        end
        tick();
        total++;
        if (phase !== 3'd0 || busy !== 1'b0 || instr_count !== 4'd0) begin
            bad++;
            $display("FAIL step_idle got ph=%0d b=%b cnt=%0d exp ph=0 b=0 cnt=0", phase, busy, instr_count);
        end
`endif
    endtask

    task automatic test_run_drop();
        do_reset();
        opcd = 3'b011; run = 1'b1;
        repeat (3) tick();
        run = 1'b0;
        for (int k = 4; k <= 7; k++) begin
            tick();
            total++;
            if (phase !== 3'(k) || busy !== 1'b1) begin
                bad++;
                $display("FAIL drop_finish k=%0d got ph=%0d b=%b exp ph=%0d b=1", k, phase, busy, k);
            end
        end
        repeat (2) tick();
        total++;
        if (phase !== 3'd0 || busy !== 1'b0 || instr_count !== 4'd1) begin
            bad++;
            $display("FAIL drop_stop got ph=%0d b=%b cnt=%0d exp ph=0 b=0 cnt=1", phase, busy, instr_count);
        end
        run = 1'b1;
        repeat (5) tick();
        total++;
        if (phase !== 3'd5) begin
            bad++;
            $display("FAIL drop_restart got ph=%0d exp 5", phase);
        end
        rst = 1'b0;
        tick();
        total++;
        if ({clk1, clk2, fch} !== 3'b011 || phase !== 3'd0 || halted !== 1'b0 ||
            busy !== 1'b0 || instr_count !== 4'd0) begin
            bad++;
            $display("FAIL mid_reset got seq=%b ph=%0d h=%b b=%b cnt=%0d exp seq=011 ph=0 h=0 b=0 cnt=0",
                     {clk1, clk2, fch}, phase, halted, busy, instr_count);
        end
        rst = 1'b1; run = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        opcd = 3'b110; run = 1'b1;
        repeat (CNT_MOD * 8 - 1) tick();
        total++;
        if (instr_count !== 4'hF || phase !== 3'd7) begin
            bad++;
            $display("FAIL wrap_max got cnt=%0d ph=%0d exp cnt=15 ph=7", instr_count, phase);
        end
        tick();
        total++;
        if (instr_count !== 4'd0) begin
            bad++;
            $display("FAIL wrap_zero got cnt=%0d exp 0", instr_count);
        end
        run = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 199) != 0);
            run     = ($urandom_range(0, 3) != 0);
            step    = ($urandom_range(0, 7) == 0);
            mem_rdy = ($urandom_range(0, 2) != 0);
            opcd    = ($urandom_range(0, 39) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            tick();
            total++;
            if ({clk1, clk2, fch} !== exp_seq(m_phase) || phase !== 3'(m_phase) ||
                halted !== m_halted || busy !== (m_mode == M_RUN || m_mode == M_STEP) ||
                instr_count !== 4'(m_cnt)) begin
                bad++;
                $display("FAIL random i=%0d got seq=%b ph=%0d h=%b b=%b cnt=%0d exp seq=%b ph=%0d h=%b b=%0d cnt=%0d",
                         i, {clk1, clk2, fch}, phase, halted, busy, instr_count,
                         exp_seq(m_phase), m_phase, m_halted,
                         (m_mode == M_RUN || m_mode == M_STEP), m_cnt);
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_run_seq();
        test_stall();
        test_halt();
        test_step();
        test_run_drop();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/risc_phase_sequencer.md
# risc_phase_sequencer

Generates the 8-phase `{clk1, clk2, fch}` sequence that drives the CPU control decoder; it is the initiator on that interface. One instruction takes eight phases: a four-phase fetch half (`fch=1`) followed by a four-phase execute half (`fch=0`). The block starts, stops, single-steps and halts the CPU, stalls on memory wait, and counts retired instructions. It sits between the top-level run control and the control decoder, and takes the opcode from the instruction register.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.

- `clk`, input, 1: system clock; every register updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-low.
- `run`, input, 1: level. 1 means free-run; 0 means stop at the next instruction boundary.
- `step`, input, 1: single-cycle pulse requesting one instruction (honoured only with `PHSEQ_STEP_EN`).
- `opcd`, input, 3: opcode from the instruction register, valid from P3 onward.
- `mem_rdy`, input, 1: memory ready; 0 stalls the sequencer in memory phases.
- `clk1`, output, 1: phase bit 2 to the decoder.
- `clk2`, output, 1: phase bit 1 to the decoder.
- `fch`, output, 1: fetch-half flag to the decoder.
- `phase`, output, 3: current phase index P0–P7.
- `halted`, output, 1: HLT has been executed.
- `busy`, output, 1: 1 in RUN or STEP.
- `instr_count`, output, CNT_W: number of retired instructions.

## Operation
- **Phase to `{clk1,clk2,fch}` mapping:**
  - P0 = 011, P1 = 111, P2 = 001, P3 = 101
  - P4 = 010, P5 = 110, P6 = 000, P7 = 100
- **Memory phases:** P1–P3, plus P5–P7 when `opcd` is 010–101.
- **Mode FSM:** STOP, RUN, STEP, HALT.
- **Reset:** mode STOP, `phase`=P0 (outputs 0/1/1), `halted`=0, `busy`=0, `instr_count`=0.
- **STOP:** phase held at P0.
  - `run`=1 goes to RUN.
  - Otherwise, `step`=1 goes to STEP.
  - If both are high, RUN wins.
- **RUN:**
  - The phase advances by 1 per cycle, except it holds while `mem_rdy`=0 in a memory phase.
  - P7→P0 increments `instr_count`.
  - If `run`=0 is sampled on the P7 advance, the next mode is STOP at P0. Deassertion at any other time has no effect until P7.
- **STEP:** advances exactly as in RUN; P7→P0 increments the count and returns to STOP. `step` pulses while not in STOP are ignored.
- **HLT (`opcd`=000):**
  - In P4 in RUN or STEP, the block does not advance to P5.
  - Next state is HALT, `phase`=P0, `halted`=1, `busy`=0, and `instr_count` increments.
  - HALT exits only on reset; `run` and `step` are ignored there.
- **Counter:** `instr_count` wraps from all-ones to 0 and saturates nowhere.
- **Stall precedence:** a stall takes precedence over the `run`=0 stop check. Stalled P7 cycles neither count nor stop.

## Timing
- All outputs are registered and change only on the `clk` edge.
- Phase/seq latency:
  - One cycle from the `run` rise in STOP to P1 on the outputs.
  - One cycle from a `step` pulse to P1.
- HLT: the outputs show P0 with `halted`=1 one cycle after the P4 cycle in which `opcd`=000.
- A `mem_rdy` low sampled in a memory phase keeps the same phase on the next cycle. The phase resumes one cycle after `mem_rdy` returns high.
- Reset mid-instruction: the next edge forces the reset values, regardless of mode or stall.
- Uninterrupted throughput: 8 cycles per instruction, 1 instruction retired per 8 cycles.

## Configuration
- **`PHSEQ_STEP_EN` defined:** the STEP mode and `step` input are active as described above.
- **`PHSEQ_STEP_EN` undefined:**
  - The `step` port remains but is ignored.
  - The STEP state is not synthesised.
  - STOP leaves only on `run`=1.

## Structure
- **Shared package `risc_pkg`:**
  - Opcode constants: OP_HLT=000, OP_SKZ=001, OP_ADD=010, OP_AND=011, OP_XOR=100, OP_LDA=101, OP_STO=110, OP_JMP=111.
  - Phase index constants P0–P7.
  - The mode enum.
  - The phase-to-seq encoding function.
- **Sub-module `phase_encode`:** combinational P-index → `{clk1,clk2,fch}`, including the memory-phase flag given `opcd`. The sequencer registers its output.

## Test plan
- Reset, then `run`=1 with `opcd`=010 and `mem_rdy`=1 for 16 cycles → seq 011,111,001,101,010,110,000,100 repeated twice; `instr_count`=2.
- `mem_rdy`=0 for 3 cycles at P2 → P2 is held for 3 extra cycles, then P3; `instr_count` is delayed by 3 cycles.
- `opcd`=000 reaching P4 → next cycle `phase`=P0, `halted`=1, `busy`=0, `instr_count`=1. `run`/`step` afterward cause no change until reset.
- With `PHSEQ_STEP_EN`, a single `step` pulse in STOP → exactly 8 phases, then STOP at P0 with `instr_count`+1. A second pulse mid-instruction is ignored.
- `run` dropped at P3 → the instruction completes through P7, then STOP at P0. `rst`=0 asserted at P5 of a later instruction → next cycle all outputs are at their reset values.
